fusion_mac_ctrl: RTL

Sequencing controller for one bit-fusible `fusion_unit` multiplier.
- Accepts a precision configuration and an operand-pair count, then streams operand pairs into the unit.
- Accumulates the unit's packed 64-bit product word into four 32-bit lane accumulators.
- Returns the finished dot-product lanes on a valid/ready result port.
- Sits between the PE operand buffers and the output/partial-sum path. The fusion unit itself is instantiated outside this block.

---
 rtl/fusion_mac_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/fusion_mac_ctrl.sv
// fusion_mac_ctrl: streams operand pairs into a fusion_unit and accumulates its packed products into four 32-bit lanes.
// Define FUSION_MAC_SAT_EN for saturating lane accumulation; otherwise lanes wrap modulo 2^32.
module fusion_mac_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_cfga,
  input  logic [1:0]        cfg_cfgb,
  input  logic              cfg_sa,
  input  logic              cfg_sb,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_a,
  input  logic [7:0]        in_b,
  output logic [7:0]        fu_a,
  output logic [7:0]        fu_b,
  output logic              fu_sa,
  output logic              fu_sb,
  output logic [1:0]        fu_cfga,
  output logic [1:0]        fu_cfgb,
  input  logic [63:0]       fu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [127:0]      res_data,
  output logic [2:0]        res_lanes,
  output logic              res_err
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
  logic [1:0] state, ca, cb;
  logic sa_r, sb_r, sgn, pend, cfg_fire, in_fire, bad;
  logic [LEN_W-1:0] cnt;
  logic [2:0] nl, cfg_nl;
  logic [31:0] acc [4];
  logic [31:0] add [4];
  logic [31:0] nxt [4];
  assign cfg_ready = state == IDLE;
  assign in_ready  = state == RUN;
  assign res_valid = state == DONE;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign bad       = (&cfg_cfga) | (&cfg_cfgb);
  assign sgn       = sa_r | sb_r;
  assign cfg_nl    = (cfg_cfga == 2'b10 && cfg_cfgb == 2'b10) ? 3'd1 :
                     ((cfg_cfga == 2'b10 && cfg_cfgb == 2'b01) ||
                      (cfg_cfga == 2'b01 && cfg_cfgb == 2'b10)) ? 3'd2 : 3'd4;
  assign res_lanes = nl;
  assign res_data  = {acc[3], acc[2], acc[1], acc[0]};
  for (genvar k = 0; k < 4; k++) begin : g_lane
    // 4-lane mode takes 16-bit fields; wider modes take whole 32-bit words
    if (k < 2) begin : g_lo
      assign add[k] = nl == 3'd1 ? (k == 0 ? fu_out[31:0] : 32'd0) :
                      nl == 3'd2 ? fu_out[32*k +: 32] :
                      {{16{sgn & fu_out[16*k+15]}}, fu_out[16*k +: 16]};
    end else begin : g_hi
      assign add[k] = nl == 3'd4 ? {{16{sgn & fu_out[16*k+15]}}, fu_out[16*k +: 16]} : 32'd0;
    end
`ifdef FUSION_MAC_SAT_EN
    logic [32:0] sum;
    assign sum    = {sgn & acc[k][31], acc[k]} + {sgn & add[k][31], add[k]};
    assign nxt[k] = sgn ? ((sum[32] ^ sum[31]) ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0])
                        : (sum[32] ? 32'hFFFF_FFFF : sum[31:0]);
`else
    assign nxt[k] = acc[k] + add[k];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ca      <= 2'd0;
      cb      <= 2'd0;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      cnt     <= '0;
      nl      <= 3'd0;
      pend    <= 1'b0;
      res_err <= 1'b0;
      fu_a    <= 8'd0;
      fu_b    <= 8'd0;
      fu_sa   <= 1'b0;
      fu_sb   <= 1'b0;
      fu_cfga <= 2'd0;
      fu_cfgb <= 2'd0;
      for (int i = 0; i < 4; i++) acc[i] <= 32'd0;
    end else begin
      pend <= in_fire;
      if (in_fire) begin
        fu_a    <= in_a;
        fu_b    <= in_b;
        fu_sa   <= sa_r;
        fu_sb   <= sb_r;
        fu_cfga <= ca;
        fu_cfgb <= cb;
        cnt     <= cnt - LEN_W'(1);
      end
      for (int i = 0; i < 4; i++)
        if (pend) acc[i] <= nxt[i];
        else if (cfg_fire) acc[i] <= 32'd0;
      if (cfg_fire) begin
        ca      <= cfg_cfga;
        cb      <= cfg_cfgb;
        sa_r    <= cfg_sa;
        sb_r    <= cfg_sb;
        cnt     <= cfg_len;
        nl      <= cfg_nl;
        res_err <= bad;
      end
      case (state)
        IDLE:    if (cfg_fire) state <= (bad || cfg_len == '0) ? DONE : RUN;
        RUN:     if (in_fire && cnt == LEN_W'(1)) state <= FLUSH;
        FLUSH:   state <= DONE;
        default: if (res_ready) state <= IDLE;
      endcase
    end
  end
endmodule
